seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for the 4-digit 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan: debounced per-digit enables, blank gap before each digit slot.
// Latency: seg/an registered, change on the slot/state edge; req->req_stable = 2 sync + DEBOUNCE_CYC cycles.
// Backpressure: none; free-running scan, frame period fixed at 4*REFRESH_DIV cycles.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 16,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] digit_seg,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic [3:0]  req_stable
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  logic [3:0]    req_m, req_s, req_p;
  logic [DW-1:0] deb_cnt [4];
  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  state_t        state, state_nxt;
  logic          en, en_nxt;
  logic [7:0]    pat, pat_nxt, seg_nxt;
  logic [3:0]    an_nxt, an_sel;
  logic [7:0]    cur_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_m <= '0;
      req_s <= '0;
      req_p <= '0;
    end else begin
      req_m <= req;
      req_s <= req_m;
      req_p <= req_s;
    end
  end

  // Any edge on the synchronised request restarts its stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      req_stable <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_s[i] != req_p[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != DEB_LAST) begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
          if (deb_cnt[i] == DEB_LAST - 1'b1) req_stable[i] <= req_s[i];
        end else begin
          req_stable[i] <= req_s[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign an_sel  = ~(4'b0001 << idx);
  assign cur_pat = digit_seg[{idx, 3'b000} +: 8];

  // Enable and pattern are captured once per slot so a digit never tears mid-slot.
  always_comb begin
    state_nxt = state;
    en_nxt    = en;
    pat_nxt   = pat;
    seg_nxt   = 8'hFF;
    an_nxt    = 4'hF;
    case (state)
      BLANK: begin
        if (slot_cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          en_nxt    = req_stable[idx];
          pat_nxt   = cur_pat;
          if (en_nxt) begin
            seg_nxt = pat_nxt;
            an_nxt  = an_sel;
          end
        end
      end
      SHOW: begin
        if (slot_cnt == SLOT_LAST) begin
          state_nxt = BLANK;
        end else if (en) begin
          seg_nxt = pat;
          an_nxt  = an_sel;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      en         <= 1'b0;
      pat        <= 8'hFF;
      seg        <= 8'hFF;
      an         <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      en         <= en_nxt;
      pat        <= pat_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= (slot_cnt == SLOT_LAST) && (idx == 2'd3);
    end
  end

endmodule
